mw_add_seq: RTL and testbench

MW_ADD_SEQ -- requirements
Module: mw_add_seq

---
 rtl/mw_add_seq.sv | 144 ++++++++++++++
 tb/tb_mw_add_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mw_add_seq.sv
// Multi-word adder sequencer: feeds an external 16-bit adder one slice per clock,
// rippling the carry through a register and collecting the NSLICE*16-bit result.
module mw_add_seq #(
  parameter int NSLICE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NSLICE*16-1:0]   a_in,
  input  logic [NSLICE*16-1:0]   b_in,
  input  logic                   cin,
  output logic [15:0]            add_a,
  output logic [15:0]            add_b,
  output logic                   add_cin,
  input  logic [15:0]            add_sum,
  input  logic                   add_cout,
  output logic [NSLICE*16-1:0]   sum_out,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = NSLICE * 16;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [KW+3:0]   ofs_s;

  // Bit offset of the active slice: k * 16.
  assign ofs_s = {k_q, 4'b0000};

  // Drive the external adder with the active slice; quiet zeros outside ADD.
  always_comb begin
    add_a   = 16'h0000;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    if (state_q == ADD) begin
      add_a   = a_q[ofs_s +: 16];
      add_b   = b_q[ofs_s +: 16];
      add_cin = carry_q;
    end else begin
      add_a   = 16'h0000;
      add_b   = 16'h0000;
      add_cin = 1'b0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          k_d     = {KW{1'b0}};
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        sum_d[ofs_s +: 16] = add_sum;
        carry_d            = add_cout;
        if (k_q == K_LAST) begin
          state_d = DONE;
          cout_d  = add_cout;
          // Signed overflow: operands agree in sign, result sign differs.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[15] != a_q[W-1]);
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= {KW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum_out = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mw_add_seq.sv
// Self-checking bench for mw_add_seq: external 16-bit adder modelled here,
// results compared against whole-word arithmetic.
module tb_mw_add_seq;

  localparam int NS = 4;
  localparam int W  = NS * 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          cin;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_cin;
  logic [15:0]   add_sum;
  logic          add_cout;
  logic [W-1:0]  sum_out;
  logic          cout;
  logic          ovf;
  logic          busy;
  logic          done;

  int            n_total = 0;
  int            n_pass  = 0;
  logic [W-1:0]  prev_sum;

  mw_add_seq #(.NSLICE(NS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .sum_out  (sum_out),
    .cout     (cout),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  // External 16-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0]   full;
    logic         o;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    o    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {o, full[W], full[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W+1:0] r;
    int cyc;
    int bcnt;
    r = ref_add(a, b, c);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c;
    chk({tag, ":busy_accept"}, busy, 1);
    chk({tag, ":sum_held"}, sum_out, prev_sum);
    chk({tag, ":slice0_a"}, add_a, a[15:0]);
    chk({tag, ":slice0_b"}, add_b, b[15:0]);
    chk({tag, ":slice0_cin"}, add_cin, c);
    cyc = 0; bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
    chk({tag, ":latency"}, cyc, NS);
    chk({tag, ":busy_cycles"}, bcnt, NS);
    chk({tag, ":sum"}, sum_out, r[W-1:0]);
    chk({tag, ":cout"}, cout, r[W]);
    chk({tag, ":ovf"}, ovf, r[W+1]);
    tick();
    chk({tag, ":done_pulse"}, done, 0);
    chk({tag, ":sum_stable"}, sum_out, r[W-1:0]);
    chk({tag, ":idle_add_a"}, {add_cin, add_a}, 0);
    prev_sum = r[W-1:0];
  endtask

  initial begin
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    int dcnt;
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    prev_sum = '0;
    tick(); tick(); tick();
    chk("rst_sum", sum_out, 0);
    chk("rst_flags", {cout, ovf, busy, done}, 0);
    chk("rst_add_out", {add_cin, add_b, add_a}, 0);

    // Start on the very first edge after reset release.
    reset = 1'b0;
    run_op("carry_slice", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    chk("carry_slice:exact", sum_out, 64'h0000_0000_0001_0000);
    run_op("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk("full_wrap:exact", {cout, sum_out}, {1'b1, 64'h0});
    run_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk("signed_ovf:exact", {ovf, sum_out}, {1'b1, 64'h8000_0000_0000_0000});
    run_op("cin_only", 64'h0, 64'h0, 1'b1);
    chk("cin_only:exact", {cout, sum_out}, {1'b0, 64'h1});
    run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);

    // Start while busy: second request must be ignored.
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    r = ref_add(ra, rb, 1'b0);
    a_in = ra; b_in = rb; cin = 1'b0; start = 1'b1;
    dcnt = 0;
    tick();
    start = 1'b0;
    tick();
    a_in = ~ra; b_in = 64'h1234_5678_9ABC_DEF0; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      tick();
    end
    chk("busy_start:done_count", dcnt, 1);
    chk("busy_start:sum", sum_out, r[W-1:0]);
    chk("busy_start:cout", cout, r[W]);
    chk("busy_start:idle", busy, 0);
    prev_sum = r[W-1:0];

    // Reset in the middle of an addition (k = 2).
    a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'h1; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("midrst:in_add", busy, 1);
    reset = 1'b1;
    tick();
    chk("midrst:busy", busy, 0);
    chk("midrst:done", done, 0);
    chk("midrst:sum", sum_out, 0);
    chk("midrst:cout", cout, 0);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcnt++;
      tick();
    end
    chk("midrst:no_done", dcnt, 0);
    prev_sum = '0;
    run_op("after_rst", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);

    // Randomized operands, biased toward carry chains and sign edges.
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: begin ra[W-1] = 1'b0; rb[W-1] = 1'b0; end
        2: begin ra[W-1] = 1'b1; rb[W-1] = 1'b1; end
        default: ;
      endcase
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
